// File: rtl/awb_gain_est.sv
// Gray-world AWB gain estimator: per-channel frame sums/counts -> K_R/K_B (U8.8) via serial divide.
// Optional macro AWB_SMOOTH_EN: DONE blends new gains as (3*K_old + K_calc) >> 2.
module awb_gain_est #(
    parameter int unsigned CNT_W = 20,
    parameter int unsigned SUM_W = 28
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic [1:0]  color_i,
    input  logic [7:0]  value_i,
    input  logic        last_i,
    output logic [15:0] K_R,
    output logic [15:0] K_G,
    output logic [15:0] K_B,
    output logic        valid_gain_o,
    output logic        gain_update_o,
    output logic        frame_drop_o,
    output logic        busy_o
);
    localparam int unsigned PW = SUM_W + CNT_W + 8;
    localparam int unsigned RW = PW + 16;

    typedef enum logic [2:0] {
        StIdle, StSetupR, StDivR, StSetupB, StDivB, StDone
    } state_e;

    state_e r_state, w_state_nxt;

    logic [SUM_W-1:0] r_sum [3];
    logic [CNT_W-1:0] r_cnt [3];
    logic [SUM_W-1:0] w_sum_nxt [3];
    logic [CNT_W-1:0] w_cnt_nxt [3];
    logic [SUM_W-1:0] r_snap_sum [3];
    logic [CNT_W-1:0] r_snap_cnt [3];
    logic             w_frame_end;

    logic [RW-1:0] r_rem, r_div;
    logic [14:0]   r_quo;
    logic [3:0]    r_bitcnt;
    logic          r_force;
    logic [15:0]   r_force_val;
    logic [15:0]   r_kr_calc, r_kb_calc;
    logic [15:0]   r_kr, r_kb;
    logic          r_valid_gain, r_gain_update, r_frame_drop;

    logic [SUM_W-1:0] w_ch_sum;
    logic [CNT_W-1:0] w_ch_cnt;
    logic [PW-1:0]    w_num, w_den;
    logic             w_unity, w_sat, w_sub_ok, w_div_last;
    logic [15:0]      w_result, w_kr_load, w_kb_load;

    assign w_frame_end = valid_i & last_i;

    // A saturated count freezes its channel so sum can never overflow.
    always_comb begin
        for (int c = 0; c < 3; c++) begin
            w_sum_nxt[c] = r_sum[c];
            w_cnt_nxt[c] = r_cnt[c];
            if (valid_i && (color_i == 2'(c)) && !(&r_cnt[c])) begin
                w_sum_nxt[c] = r_sum[c] + SUM_W'(value_i);
                w_cnt_nxt[c] = r_cnt[c] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < 3; c++) begin
                r_sum[c]      <= '0;
                r_cnt[c]      <= '0;
                r_snap_sum[c] <= '0;
                r_snap_cnt[c] <= '0;
            end
        end else begin
            for (int c = 0; c < 3; c++) begin
                if (w_frame_end) begin
                    r_sum[c] <= '0;
                    r_cnt[c] <= '0;
                end else begin
                    r_sum[c] <= w_sum_nxt[c];
                    r_cnt[c] <= w_cnt_nxt[c];
                end
                if (w_frame_end && (r_state == StIdle)) begin
                    r_snap_sum[c] <= w_sum_nxt[c];
                    r_snap_cnt[c] <= w_cnt_nxt[c];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign w_div_last = (r_bitcnt == 4'd15);

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle:   if (w_frame_end) w_state_nxt = StSetupR;
            StSetupR: w_state_nxt = StDivR;
            StDivR:   if (w_div_last) w_state_nxt = StSetupB;
            StSetupB: w_state_nxt = StDivB;
            StDivB:   if (w_div_last) w_state_nxt = StDone;
            StDone:   w_state_nxt = StIdle;
            default:  w_state_nxt = StIdle;
        endcase
    end

    // Shared multipliers: the setup state selects which colour channel is divided.
    always_comb begin
        w_ch_sum = (r_state == StSetupB) ? r_snap_sum[2] : r_snap_sum[0];
        w_ch_cnt = (r_state == StSetupB) ? r_snap_cnt[2] : r_snap_cnt[0];
        w_num    = (PW'(r_snap_sum[1]) * PW'(w_ch_cnt)) << 8;
        w_den    = PW'(w_ch_sum) * PW'(r_snap_cnt[1]);
        w_unity  = (w_ch_sum == '0) || (w_ch_cnt == '0) || (r_snap_cnt[1] == '0);
        w_sat    = (RW'(w_num) >= (RW'(w_den) << 16));
        w_sub_ok = (r_rem >= r_div);
        w_result = r_force ? r_force_val : {r_quo, w_sub_ok};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem       <= '0;
            r_div       <= '0;
            r_quo       <= '0;
            r_bitcnt    <= '0;
            r_force     <= 1'b0;
            r_force_val <= 16'h0100;
            r_kr_calc   <= 16'h0100;
            r_kb_calc   <= 16'h0100;
        end else begin
            case (r_state)
                StSetupR, StSetupB: begin
                    r_rem       <= RW'(w_num);
                    r_div       <= RW'(w_den) << 15;
                    r_quo       <= '0;
                    r_bitcnt    <= '0;
                    r_force     <= w_unity | w_sat;
                    r_force_val <= w_unity ? 16'h0100 : 16'hFFFF;
                end
                StDivR, StDivB: begin
                    if (w_sub_ok) begin
                        r_rem <= r_rem - r_div;
                    end
                    r_div    <= r_div >> 1;
                    r_quo    <= {r_quo[13:0], w_sub_ok};
                    r_bitcnt <= r_bitcnt + 4'd1;
                    if (w_div_last) begin
                        if (r_state == StDivR) begin
                            r_kr_calc <= w_result;
                        end else begin
                            r_kb_calc <= w_result;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef AWB_SMOOTH_EN
    always_comb begin
        w_kr_load = r_kr_calc;
        w_kb_load = r_kb_calc;
        if (r_valid_gain) begin
            w_kr_load = 16'((18'(r_kr) * 18'd3 + 18'(r_kr_calc)) >> 2);
            w_kb_load = 16'((18'(r_kb) * 18'd3 + 18'(r_kb_calc)) >> 2);
        end
    end
`else
    assign w_kr_load = r_kr_calc;
    assign w_kb_load = r_kb_calc;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_kr          <= 16'h0100;
            r_kb          <= 16'h0100;
            r_valid_gain  <= 1'b0;
            r_gain_update <= 1'b0;
            r_frame_drop  <= 1'b0;
        end else begin
            r_gain_update <= (r_state == StDone);
            r_frame_drop  <= w_frame_end && (r_state != StIdle);
            if (r_state == StDone) begin
                r_kr         <= w_kr_load;
                r_kb         <= w_kb_load;
                r_valid_gain <= 1'b1;
            end
        end
    end

    assign K_R           = r_kr;
    assign K_G           = 16'h0100;
    assign K_B           = r_kb;
    assign valid_gain_o  = r_valid_gain;
    assign gain_update_o = r_gain_update;
    assign frame_drop_o  = r_frame_drop;
    assign busy_o        = (r_state != StIdle);

endmodule

// File: tb/tb_awb_gain_est.sv
// Directed bench for awb_gain_est: table of single-frame vectors plus drop/reset/smoothing sequences.
module tb_awb_gain_est;
    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i, last_i;
    logic [1:0]  color_i;
    logic [7:0]  value_i;
    logic [15:0] K_R, K_G, K_B;
    logic        valid_gain_o, gain_update_o, frame_drop_o, busy_o;

    awb_gain_est dut (
        .clk           (clk),
        .rst           (rst),
        .valid_i       (valid_i),
        .color_i       (color_i),
        .value_i       (value_i),
        .last_i        (last_i),
        .K_R           (K_R),
        .K_G           (K_G),
        .K_B           (K_B),
        .valid_gain_o  (valid_gain_o),
        .gain_update_o (gain_update_o),
        .frame_drop_o  (frame_drop_o),
        .busy_o        (busy_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string           name;
        int              npix;
        logic [9:0][1:0] col;
        logic [9:0][7:0] val;
        logic [15:0]     kr;
        logic [15:0]     kb;
    } vec_t;

    vec_t vecs[7];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic new_vec(input int v, input string name, input logic [15:0] kr,
                           input logic [15:0] kb);
        vecs[v].name = name;
        vecs[v].npix = 0;
        vecs[v].col  = '0;
        vecs[v].val  = '0;
        vecs[v].kr   = kr;
        vecs[v].kb   = kb;
    endtask

    task automatic pix(input int v, input logic [1:0] c, input logic [7:0] x);
        vecs[v].col[vecs[v].npix] = c;
        vecs[v].val[vecs[v].npix] = x;
        vecs[v].npix++;
    endtask

    task automatic do_reset();
        rst = 1'b1; valid_i = 1'b0; last_i = 1'b0; color_i = 2'd0; value_i = 8'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic send_frame(input int v, output int e0);
        for (int i = 0; i < vecs[v].npix; i++) begin
            valid_i = 1'b1;
            color_i = vecs[v].col[i];
            value_i = vecs[v].val[i];
            last_i  = (i == vecs[v].npix - 1);
            @(posedge clk); #1;
        end
        valid_i = 1'b0;
        last_i  = 1'b0;
        e0      = cyc;
    endtask

    task automatic wait_update(input int e0, output int lat);
        lat = -1;
        for (int k = 0; k < 60; k++) begin
            if (gain_update_o) begin
                lat = cyc - e0;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int e0, e1, lat, pulses;

        new_vec(0, "t1", 16'h0200, 16'h0400);
        pix(0, 2'd0, 8'd64); pix(0, 2'd1, 8'd128); pix(0, 2'd1, 8'd128); pix(0, 2'd2, 8'd32);
        new_vec(1, "t2_sat", 16'hFFFF, 16'h1980);
        pix(1, 2'd0, 8'd1); pix(1, 2'd0, 8'd0); pix(1, 2'd0, 8'd0); pix(1, 2'd0, 8'd0);
        for (int i = 0; i < 4; i++) pix(1, 2'd1, 8'd255);
        pix(1, 2'd2, 8'd10);
        new_vec(2, "t3_noB", 16'h0100, 16'h0100);
        pix(2, 2'd0, 8'd100); pix(2, 2'd1, 8'd100);
        new_vec(3, "t3_zeroB", 16'h0100, 16'h0100);
        pix(3, 2'd0, 8'd100); pix(3, 2'd1, 8'd100); pix(3, 2'd2, 8'd0); pix(3, 2'd2, 8'd0);
        new_vec(4, "r50g200b100", 16'h0400, 16'h0200);
        pix(4, 2'd0, 8'd50); pix(4, 2'd1, 8'd200); pix(4, 2'd2, 8'd100);
        new_vec(5, "frac_ign", 16'h0155, 16'h0092);
        pix(5, 2'd0, 8'd3); pix(5, 2'd1, 8'd4); pix(5, 2'd3, 8'd255); pix(5, 2'd2, 8'd7);
        new_vec(6, "r128", 16'h0100, 16'h0400);
        pix(6, 2'd0, 8'd128); pix(6, 2'd1, 8'd128); pix(6, 2'd1, 8'd128); pix(6, 2'd2, 8'd32);

        do_reset();
        check("rst_K_R", K_R, 16'h0100);
        check("rst_K_G", K_G, 16'h0100);
        check("rst_K_B", K_B, 16'h0100);
        check("rst_valid", valid_gain_o, 0);
        check("rst_upd", gain_update_o, 0);
        check("rst_drop", frame_drop_o, 0);
        check("rst_busy", busy_o, 0);

        for (int v = 0; v < 6; v++) begin
            do_reset();
            send_frame(v, e0);
            @(posedge clk); #1;
            check({vecs[v].name, "_busy"}, busy_o, 1);
            wait_update(e0, lat);
            check({vecs[v].name, "_lat"}, lat, 35);
            check({vecs[v].name, "_K_R"}, K_R, vecs[v].kr);
            check({vecs[v].name, "_K_B"}, K_B, vecs[v].kb);
            check({vecs[v].name, "_K_G"}, K_G, 16'h0100);
            check({vecs[v].name, "_valid"}, valid_gain_o, 1);
            @(posedge clk); #1;
            check({vecs[v].name, "_upd_1cyc"}, gain_update_o, 0);
            check({vecs[v].name, "_idle"}, busy_o, 0);
        end

        // Second frame end 10 cycles after the first is dropped.
        do_reset();
        send_frame(0, e0);
        repeat (9) @(posedge clk);
        #1;
        check("t4_no_drop_yet", frame_drop_o, 0);
        valid_i = 1'b1; color_i = 2'd1; value_i = 8'd200; last_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0; last_i = 1'b0;
        check("t4_drop", frame_drop_o, 1);
        @(posedge clk); #1;
        check("t4_drop_1cyc", frame_drop_o, 0);
        wait_update(e0, lat);
        check("t4_lat", lat, 35);
        check("t4_K_R", K_R, 16'h0200);
        check("t4_K_B", K_B, 16'h0400);
        @(posedge clk); #1;
        send_frame(0, e1);
        wait_update(e1, lat);
        check("t4_third_lat", lat, 35);
        check("t4_third_K_R", K_R, 16'h0200);
        check("t4_third_K_B", K_B, 16'h0400);

        // Reset in the middle of the blue division.
        do_reset();
        send_frame(0, e0);
        repeat (19) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("t5_K_R", K_R, 16'h0100);
        check("t5_K_B", K_B, 16'h0100);
        check("t5_valid", valid_gain_o, 0);
        check("t5_busy", busy_o, 0);
        pulses = 0;
        for (int k = 0; k < 30; k++) begin
            if (gain_update_o) pulses++;
            @(posedge clk); #1;
        end
        check("t5_no_update", pulses, 0);
        check("t5_K_R_hold", K_R, 16'h0100);
        send_frame(0, e0);
        wait_update(e0, lat);
        check("t5_rerun_lat", lat, 35);
        check("t5_rerun_K_R", K_R, 16'h0200);
        check("t5_rerun_K_B", K_B, 16'h0400);

        // Two consecutive updates: blended when smoothing is built in.
        do_reset();
        send_frame(0, e0);
        wait_update(e0, lat);
        check("t6_first_K_R", K_R, 16'h0200);
        @(posedge clk); #1;
        send_frame(6, e0);
        wait_update(e0, lat);
        check("t6_lat", lat, 35);
`ifdef AWB_SMOOTH_EN
        check("t6_second_K_R", K_R, 16'h01C0);
`else
        check("t6_second_K_R", K_R, vecs[6].kr);
`endif
        check("t6_second_K_B", K_B, 16'h0400);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
